// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared definitions.
// State, owner encodings and default constants.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_READ = 1'b1
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

    localparam logic [31:0] NOP_ADDR_DEFAULT = 32'hffff_ffff;
    localparam logic [31:0] WMASK_FULL       = 32'hffff_ffff;

endpackage

// File: rtl/mem_arbiter_grant.sv
// mem_arbiter grant decision, purely combinational.
// MEM_ARBITER_ROUND_ROBIN_EN selects round-robin over D-priority.
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
(
    input  logic if_start,
    input  logic d_start,
    input  logic mem_cmd_ready,
    input  logic idle,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    input  logic last_grant,
`else
    input  logic starve_hit,
`endif
    output logic grant_if,
    output logic grant_d
);

    logic if_pref;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    assign if_pref = (last_grant == OWNER_D);
`else
    assign if_pref = starve_hit;
`endif

    // Pick at most one winner when the port can issue.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (idle && mem_cmd_ready) begin
            if (if_start && d_start) begin
                grant_if = if_pref;
                grant_d  = !if_pref;
            end else begin
                grant_if = if_start;
                grant_d  = d_start;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters onto one memory controller port.
// Optional MEM_ARBITER_ROUND_ROBIN_EN replaces starvation counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] NOP_ADDR     = NOP_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_start,
    output logic        if_ready,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_rdata_valid,
    input  logic        d_start,
    input  logic        d_write,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_rdata_valid,
    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_wmask
);

    state_t state;
    owner_t owner;
    logic   grant_if;
    logic   grant_d;
    logic   idle;
    logic   d_read_go;
    logic   resp;

    // Issue is also blocked while reset is asserted.
    assign idle      = (state == IDLE) && rst_n;
    assign d_read_go = grant_d && !d_write;
    assign resp      = (state == WAIT_READ) && mem_rdata_valid;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_grant;

    mem_arbiter_grant u_grant (
        .if_start      (if_start),
        .d_start       (d_start),
        .mem_cmd_ready (mem_cmd_ready),
        .idle          (idle),
        .last_grant    (last_grant),
        .grant_if      (grant_if),
        .grant_d       (grant_d)
    );

    // Remember the most recent winner; IF goes first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWNER_D;
        end else if (grant_if) begin
            last_grant <= OWNER_IF;
        end else if (grant_d) begin
            last_grant <= OWNER_D;
        end
    end
`else
    logic [3:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = ({28'd0, starve_cnt} >= 32'(STARVE_LIMIT));

    mem_arbiter_grant u_grant (
        .if_start      (if_start),
        .d_start       (d_start),
        .mem_cmd_ready (mem_cmd_ready),
        .idle          (idle),
        .starve_hit    (starve_hit),
        .grant_if      (grant_if),
        .grant_d       (grant_d)
    );

    // Count fetch losses to data; clear once fetch wins or goes quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (grant_if) begin
            starve_cnt <= 4'd0;
        end else if (grant_d && if_start) begin
            if (starve_cnt != 4'hf) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (state == IDLE && !if_start) begin
            starve_cnt <= 4'd0;
        end
    end
`endif

    // Track one outstanding read and its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWNER_IF;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_if) begin
                        state <= WAIT_READ;
                        owner <= OWNER_IF;
                    end else if (d_read_go) begin
                        state <= WAIT_READ;
                        owner <= OWNER_D;
                    end
                end
                WAIT_READ: begin
                    if (mem_rdata_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency command mux from the winner.
    always_comb begin
        mem_cmd_start = grant_if || grant_d;
        mem_cmd_write = 1'b0;
        mem_addr      = NOP_ADDR;
        mem_wdata     = 32'd0;
        mem_wmask     = 32'd0;
        if (grant_if) begin
            mem_addr = if_addr;
        end else if (grant_d) begin
            mem_addr      = d_addr;
            mem_cmd_write = d_write;
            mem_wdata     = d_wdata;
            mem_wmask     = d_wmask;
        end
    end

    assign if_ready       = grant_if;
    assign d_ready        = grant_d;
    assign if_rdata       = mem_rdata;
    assign d_rdata        = mem_rdata;
    assign if_rdata_valid = resp && (owner == OWNER_IF);
    assign d_rdata_valid  = resp && (owner == OWNER_D);

endmodule
